// File: rtl/bcd_scan_ctrl.sv
// Iterative binary-to-BCD converter with a four-digit multiplexed 7-segment scanner.
// Define BCD_SCAN_LEADING_ZERO_BLANK_EN to blank leading-zero digits during their scan slot.

module decoder_7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    // Active-high segments, bit order {g,f,e,d,c,b,a}; non-decimal codes are dark.
    always_comb begin
        seg = 7'h00;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

module bcd_scan_ctrl #(
    parameter int DATA_W   = 10,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       digits_bcd,
    output logic [6:0]        seg_out,
    output logic [3:0]        digit_en
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg_p0;
    logic [15:0]        acc_p0;
    logic [15:0]        acc_corr;
    logic [15:0]        acc_next;
    logic [DATA_W-1:0]  shreg_next;

    logic [PW-1:0]      presc;
    logic [1:0]         digit_idx;
    logic [3:0]         cur_nibble;
    logic [3:0]         onehot;
    logic [3:0]         blank;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] add3_correct(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 4; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        acc_corr   = add3_correct(acc_p0);
        acc_next   = {acc_corr[14:0], shreg_p0[DATA_W-1]};
        shreg_next = shreg_p0 << 1;
    end

    // Control: FSM, bit counter, result register and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            digits_bcd <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bit_cnt  <= CNT_LOAD;
                        state    <= CONV;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    bit_cnt <= bit_cnt - CNT_ONE;
                    if (bit_cnt == CNT_ONE) begin
                        digits_bcd <= acc_next;
                        done       <= 1'b1;
                        state      <= IDLE;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: load on accept, shift-add-3 while converting; only control needs reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            shreg_p0 <= in_data;
            acc_p0   <= 16'h0000;
        end else if (state == CONV) begin
            shreg_p0 <= shreg_next;
            acc_p0   <= acc_next;
        end
    end

    // Scan: prescaler wrap advances the digit slot, independent of the converter.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            digit_idx <= 2'd0;
        end else if (presc == PRESC_LAST) begin
            presc     <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        cur_nibble = digits_bcd[3:0];
        onehot     = 4'b0001;
        case (digit_idx)
            2'd0: begin cur_nibble = digits_bcd[3:0];   onehot = 4'b0001; end
            2'd1: begin cur_nibble = digits_bcd[7:4];   onehot = 4'b0010; end
            2'd2: begin cur_nibble = digits_bcd[11:8];  onehot = 4'b0100; end
            2'd3: begin cur_nibble = digits_bcd[15:12]; onehot = 4'b1000; end
            default: begin cur_nibble = digits_bcd[3:0]; onehot = 4'b0001; end
        endcase
    end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero only if it and every higher digit are zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (digits_bcd[15:12] == 4'd0);
        blank[2] = blank[3] && (digits_bcd[11:8] == 4'd0);
        blank[1] = blank[2] && (digits_bcd[7:4] == 4'd0);
        blank[0] = 1'b0;
    end
`else
    always_comb begin
        blank = 4'b0000;
    end
`endif

    assign digit_en = onehot & ~blank;

    decoder_7seg u_dec (
        .bcd (cur_nibble),
        .seg (seg_out)
    );

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl: conversion table, handshake corner cases and digit scan.
// Honours BCD_SCAN_LEADING_ZERO_BLANK_EN the same way the design does.

module tb_bcd_scan_ctrl;
    localparam int DATA_W   = 10;
    localparam int SCAN_DIV = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [15:0]       digits_bcd;
    logic [6:0]        seg_out;
    logic [3:0]        digit_en;

    bcd_scan_ctrl #(.DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .digits_bcd (digits_bcd),
        .seg_out    (seg_out),
        .digit_en   (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_edges  = 0;

    // Edges since the last reset edge; gives the expected scan slot.
    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    typedef struct {
        logic [DATA_W-1:0] din;
        logic [15:0]       bcd;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] exp_en(input int idx, input logic [15:0] b);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        if (idx == 3 && b[15:12] == 4'd0) oh = 4'b0000;
        if (idx == 2 && b[15:8] == 8'd0)  oh = 4'b0000;
        if (idx == 1 && b[15:4] == 12'd0) oh = 4'b0000;
`endif
        return oh;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [DATA_W-1:0] din, input logic [15:0] exp_bcd);
        in_valid = 1'b1;
        in_data  = din;
        tick();
        in_valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_ready", in_ready, 0);
        chk("accept_done", done, 0);
        for (int k = 1; k < DATA_W; k++) begin
            tick();
            chk("conv_busy", busy, 1);
            chk("conv_done", done, 0);
        end
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", in_ready, 1);
        chk("result_bcd", digits_bcd, exp_bcd);
        tick();
        chk("done_clear", done, 0);
        chk("result_hold", digits_bcd, exp_bcd);
    endtask

    task automatic check_scan(input int cycles, input logic [15:0] b);
        int idx;
        for (int c = 0; c < cycles; c++) begin
            idx = (n_edges / SCAN_DIV) % 4;
            chk("scan_en", digit_en, exp_en(idx, b));
            chk("scan_seg", seg_out, seg_of(4'((b >> (4 * idx)) & 16'hF)));
            tick();
        end
    endtask

    initial begin
        vecs[0]  = '{10'd0,    16'h0000};
        vecs[1]  = '{10'd1,    16'h0001};
        vecs[2]  = '{10'd9,    16'h0009};
        vecs[3]  = '{10'd10,   16'h0010};
        vecs[4]  = '{10'd99,   16'h0099};
        vecs[5]  = '{10'd100,  16'h0100};
        vecs[6]  = '{10'd255,  16'h0255};
        vecs[7]  = '{10'd512,  16'h0512};
        vecs[8]  = '{10'd999,  16'h0999};
        vecs[9]  = '{10'd1000, 16'h1000};
        vecs[10] = '{10'd1022, 16'h1022};
        vecs[11] = '{10'd1023, 16'h1023};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", digits_bcd, 16'h0000);
        chk("rst_en", digit_en, 4'b0001);
        chk("rst_seg", seg_out, 7'h3F);

        for (int i = 0; i < 12; i++)
            convert(vecs[i].din, vecs[i].bcd);

        // Offer 5 throughout the conversion of 1023; it must be ignored.
        in_valid = 1'b1;
        in_data  = 10'd1023;
        tick();
        in_data = 10'd5;
        chk("ign_busy0", busy, 1);
        for (int k = 1; k < DATA_W; k++) begin
            tick();
            chk("ign_busy", busy, 1);
            chk("ign_done", done, 0);
        end
        tick();
        chk("ign_done_pulse", done, 1);
        chk("ign_bcd", digits_bcd, 16'h1023);
        in_valid = 1'b0;
        tick();
        chk("ign_idle_busy", busy, 0);
        chk("ign_idle_ready", in_ready, 1);
        chk("ign_bcd_hold", digits_bcd, 16'h1023);
        convert(10'd5, 16'h0005);

        convert(10'd1023, 16'h1023);
        check_scan(20, 16'h1023);

        convert(10'd7, 16'h0007);
        check_scan(20, 16'h0007);

        // Reset five cycles into a conversion of 512.
        in_valid = 1'b1;
        in_data  = 10'd512;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ready", in_ready, 1);
        chk("mid_busy_clr", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_bcd", digits_bcd, 16'h0000);
        chk("mid_en", digit_en, 4'b0001);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("mid_no_done", done, 0);
            chk("mid_stay_idle", busy, 0);
        end

        // Reset wins over a simultaneous transfer.
        in_valid = 1'b1;
        in_data  = 10'd321;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("prio_busy", busy, 0);
        chk("prio_ready", in_ready, 1);
        tick();
        chk("prio_busy2", busy, 0);
        chk("prio_bcd", digits_bcd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Sequential binary-to-BCD controller and display scanner for the four-digit 7-segment readout. It accepts a binary value through a valid/ready handshake and converts it with a multi-cycle shift-add-3 (double-dabble) datapath, one bit per clock. It holds the latest BCD result and time-multiplexes the four digits onto one shared segment bus through a single `decoder_7seg` instance. It replaces four parallel divider/modulo paths and four decoders with one iterative datapath and one decoder.

## Interface
- `DATA_W`, 10: binary input width; legal range 1..13, so the maximum input of 8191 fits in four digits.
- `SCAN_DIV`, 50000: clock cycles each digit stays selected; legal range ≥1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` is offered.
- `in_data` in DATA_W: unsigned binary value to convert.
- `in_ready` out 1: high in IDLE; a transfer occurs when `in_valid & in_ready` at a rising edge.
- `busy` out 1: high while in CONV.
- `done` out 1: one-cycle pulse when `digits_bcd` has just been updated.
- `digits_bcd` out 16: latched result, {thousands, hundreds, tens, units}, 4 bits each.
- `seg_out` out 7: `decoder_7seg` output for the currently selected digit, using the decoder's own polarity.
- `digit_en` out 4: one-hot digit select, active-high; bit 0 is units, bit 3 is thousands.

## Operation
- FSM states are IDLE and CONV.
  - IDLE: `in_ready`=1. On transfer, load the shift register with `in_data`, clear the 16-bit BCD accumulator, set `bit_cnt`=DATA_W, and go to CONV.
  - CONV: `in_ready`=0 and `busy`=1. Each cycle:
    - add 3 to every accumulator nibble ≥5;
    - shift {accumulator, shift register} left by 1;
    - decrement `bit_cnt`.
  - On the cycle where `bit_cnt` reaches 0, write the final accumulator to `digits_bcd`, register `done`=1, and return to IDLE.
- Correction and shift happen in the same cycle. Correction uses the pre-shift nibble values.
- The scan is independent of the FSM.
  - Prescaler counts 0..SCAN_DIV-1. On wrap, `digit_idx` advances 0→1→2→3→0.
  - `digit_en` = onehot(`digit_idx`).
  - `seg_out` = decode(`digits_bcd` nibble[`digit_idx`]), combinational from registered state.
- The scan always shows the current `digits_bcd`. A new result takes effect on the next cycle with no scan restart.
- `in_valid` while not in IDLE is ignored; no data is captured or queued.
- Reset in any state, including mid-CONV:
  - FSM returns to IDLE and the in-progress conversion is discarded with no `done`;
  - `digits_bcd`=0, prescaler=0, `digit_idx`=0.

## Timing
- Reset values:
  - `in_ready`=1, `busy`=0, `done`=0;
  - `digits_bcd`=16'h0000, `digit_en`=4'b0001;
  - `seg_out`=decoder_7seg(0).
- Latency: transfer at edge E0. CONV occupies cycles E0..E0+DATA_W-1. At edge E0+DATA_W, `digits_bcd` updates and `done`=1 for exactly one cycle.
- `in_ready` is 1 in the same cycle as `done`. Back-to-back accepts therefore give a throughput of one conversion per DATA_W+1 cycles.
- `digit_en` changes only at a prescaler wrap, every SCAN_DIV cycles. With SCAN_DIV=1 it rotates every cycle.
- `rst` takes priority over a simultaneous transfer and over prescaler wrap.

## Configuration
- Macro: `BCD_SCAN_LEADING_ZERO_BLANK_EN`.
- Defined: leading-zero digits are blanked by forcing their `digit_en` bit to 0 during their slot. Slot timing is unchanged. Blanking rules:
  - thousands blanks if it is 0;
  - hundreds blanks if thousands and hundreds are 0;
  - tens blanks if thousands, hundreds and tens are 0;
  - units never blanks.
- Undefined: all four digits are always enabled in their slot, so leading zeros are shown.

## Test plan
- Reset: after `rst` for 1 cycle → `in_ready`=1, `busy`=0, `done`=0, `digits_bcd`=16'h0000, `digit_en`=4'b0001.
- Convert 999 (DATA_W=10): transfer at E0 → `busy` for 10 cycles, `done` pulse at E0+10, `digits_bcd`=16'h0999.
- Convert 1023, then hold `in_valid` with `in_data`=5 during CONV → `digits_bcd`=16'h1023 and the value 5 is never captured. A second transfer with 5 after `done` gives 16'h0005 10 cycles later.
- Scan with SCAN_DIV=4 and `digits_bcd`=16'h1234: `digit_en` steps 0001→0010→0100→1000→0001, each held for 4 cycles. `seg_out` equals the decode of 4, 3, 2, 1 respectively.
- Reset mid-CONV: assert `rst` 5 cycles after transfer of 512 → no `done`, `digits_bcd`=0, and IDLE with `in_ready`=1 on the next cycle.
- Blanking, converting 7: with the macro defined, `digit_en` is 0001 in the units slot and 0000 in the other three slots. With the macro undefined, the full one-hot rotation is seen.
